pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Upstream supervisor for the core PLL (74.25 MHz refclk -> 57.272/14.318/7.159/12.273 MHz outputs).
//  Drives the PLL's active-high reset input and watches its asynchronous locked output.
//  Produces a registered core_reset that is released only after lock has been stable for a
//  settle period. Re-resets the PLL on lock timeout or loss of lock, and reports status.
//  Runs entirely on refclk, which is free-running and never from the PLL.
// PARAMETERS
//  RST_CYCLES     16         refclk cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT   1_000_000  cycles to wait for lock before retrying (~13.5 ms)
//  SETTLE_CYCLES  4096       consecutive locked cycles required before core_reset release
//  MAX_RETRY      7          consecutive failed attempts that set lock_fail (1..15)
//  CNT_W          20         shared cycle-counter width; every cycle parameter must be < 2**CNT_W
// PORTS
//  refclk       in   1  free-running reference clock (74.25 MHz), sole clock
//  rst          in   1  asynchronous, active-high reset of this block
//  pll_locked   in   1  PLL locked flag, asynchronous to refclk
//  pll_rst      out  1  reset to PLL, active-high, registered
//  core_reset   out  1  reset for PLL-clocked logic, active-high, registered
//  lock_fail    out  1  sticky: MAX_RETRY consecutive attempts failed; cleared only by rst
//  retry_count  out  4  failed attempts since last RUN entry, saturates at 15
//  loss_count   out  4  lock losses while in RUN, saturates at 15
//  state_o      out  2  current FSM state (encoding per package)
// BEHAVIOUR
//  Reset (rst=1, async): state=RESET_PLL, cnt=0, pll_rst=1, core_reset=1, lock_fail=0,
//    retry_count=0, loss_count=0, sync flops=0.
//  pll_locked goes through a 2-flop synchronizer to give lk. lk lags pll_locked by 2 refclk edges.
//  All outputs are registered and reflect the state entered on the same edge.
//  RESET_PLL: pll_rst=1, core_reset=1. Stays for exactly RST_CYCLES cycles, then goes to
//    WAIT_LOCK with cnt=0. lk is ignored in this state.
//  WAIT_LOCK: pll_rst=0, core_reset=1.
//    - lk=1: go to SETTLE, cnt=0.
//    - otherwise, when cnt==LOCK_TIMEOUT-1: go to RESET_PLL and increment retry_count
//      (saturating). If the incremented value is >=MAX_RETRY, set lock_fail.
//    - otherwise cnt++.
//    - lk=1 on the timeout cycle: lock wins.
//  SETTLE: pll_rst=0, core_reset=1.
//    - lk=0: return to WAIT_LOCK. cnt is NOT cleared, so the timeout keeps running across
//      glitches; cnt saturates at LOCK_TIMEOUT-1.
//    - otherwise, after SETTLE_CYCLES consecutive cycles with lk=1: go to RUN and clear
//      retry_count. lock_fail keeps its value.
//    - SETTLE uses its own settle counter (same width). It is cleared on SETTLE entry.
//  RUN: pll_rst=0, core_reset=0.
//    - lk=0: core_reset=1 on the next edge, go to RESET_PLL, increment loss_count
//      (saturating), cnt=0.
//  Retries never stop. lock_fail is status only and does not halt the FSM.
//  rst asserted in any state returns to the reset values immediately.
//    core_reset is never low for any cycle while rst=1.
//  Width rules: all counter compares use CNT_W-bit unsigned values; no wrap is permitted.
// STRUCTURE
//  Package pll_sup_pkg holds:
//    - typedef enum logic[1:0] {RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, RUN=3} pll_sup_state_t
//    - localparam CNT_W_DEFAULT=20
//  Sub-module sync_2ff (WIDTH=1, refclk, async rst, reset value 0) for pll_locked.
//  The FSM, cycle counter, settle counter and status counters sit in this module.
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, MAX_RETRY=3)
//  1. Release rst, raise pll_locked at cycle 10 and hold it -> pll_rst high for cycles 0-3;
//     core_reset falls exactly 2+8 cycles after WAIT_LOCK sees lk; state_o=3; counts 0.
//  2. pll_locked held low -> pll_rst pulses 4 cycles every 54 cycles; retry_count 1,2,3;
//     lock_fail rises with the 3rd timeout; retries continue; retry_count saturates at 15.
//  3. In RUN, drop pll_locked for 1 cycle -> core_reset=1 within 3 edges; loss_count=1;
//     pll_rst pulses 4 cycles; relock then gives release after settle.
//  4. In SETTLE, glitch pll_locked low at settle count 5 -> back to WAIT_LOCK; the timeout
//     is not restarted; full 8-cycle settle is required after lk returns.
//  5. Assert rst mid-SETTLE and mid-RUN -> all outputs return to reset values asynchronously
//     (before the next refclk edge); lock_fail and both counts return to 0.
//  6. lk rising on the exact timeout cycle -> enters SETTLE; retry_count unchanged.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and helpers for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    localparam int CNT_W_DEFAULT = 20;

    // Status counters stick at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for slow asynchronous level signals
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer with lock timeout, settle delay and status
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1_000_000,
    parameter int SETTLE_CYCLES = 4096,
    parameter int MAX_RETRY     = 7,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       lock_fail,
    output logic [3:0] retry_count,
    output logic [3:0] loss_count,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIM   = 4'(MAX_RETRY);

    pll_sup_state_t   state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] settle_cnt, settle_nx;
    logic [3:0]       retry_nx, loss_nx;
    logic             fail_nx;
    logic             lk;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            settle_cnt  <= '0;
            pll_rst     <= 1'b1;
            core_reset  <= 1'b1;
            lock_fail   <= 1'b0;
            retry_count <= 4'd0;
            loss_count  <= 4'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            settle_cnt  <= settle_nx;
            pll_rst     <= (state_nx == RESET_PLL);
            core_reset  <= (state_nx != RUN);
            lock_fail   <= fail_nx;
            retry_count <= retry_nx;
            loss_count  <= loss_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        settle_nx = settle_cnt;
        retry_nx  = retry_count;
        loss_nx   = loss_count;
        fail_nx   = lock_fail;
        unique case (state)
            RESET_PLL: begin
                if (cnt >= RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (lk) begin
                    state_nx  = SETTLE;
                    cnt_nx    = '0;
                    settle_nx = '0;
                end else if (cnt >= TO_LAST) begin
                    state_nx = RESET_PLL;
                    cnt_nx   = '0;
                    retry_nx = sat_inc4(retry_count);
                    if (retry_nx >= RETRY_LIM) begin
                        fail_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SETTLE: begin
                // The lock timeout keeps running here so lock glitches cannot stall retries.
                if (cnt < TO_LAST) begin
                    cnt_nx = cnt + 1'b1;
                end
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                end else if (settle_cnt >= SETTLE_LAST) begin
                    state_nx = RUN;
                    retry_nx = 4'd0;
                end else begin
                    settle_nx = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_nx = RESET_PLL;
                    cnt_nx   = '0;
                    loss_nx  = sat_inc4(loss_count);
                end
            end
            default: begin
                state_nx = RESET_PLL;
                cnt_nx   = '0;
            end
        endcase
    end

    assign state_o = state;

endmodule
